dma_bus_arbiter: RTL and testbench

DMA_BUS_ARBITER -- requirements
Module: dma_bus_arbiter

---
 rtl/dma_bus_arbiter_pkg.sv | 14 +
 rtl/dma_bus_arbiter_rr_pick.sv | 38 +++
 rtl/dma_bus_arbiter.sv | 148 ++++++++++++++
 tb/tb_dma_bus_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/dma_bus_arbiter_pkg.sv
// Shared types and constants for the DMA bus arbiter and its round-robin picker.
package dma_bus_arbiter_pkg;

   localparam int ARB_OWNER_W = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT_IDLE,
      ST_OWN,
      ST_REL
   } arb_state_e;

endpackage

// File: rtl/dma_bus_arbiter_rr_pick.sv
// Combinational round-robin selector: first asserted request after last_owner, wrapping.
module rr_pick
   import dma_bus_arbiter_pkg::*;
#(
   parameter int NREQ = 3
) (
   input  logic [NREQ-1:0]        req,
   input  logic [ARB_OWNER_W-1:0] last_owner,
   output logic                   valid,
   output logic [ARB_OWNER_W-1:0] index
);

   logic [3:0]             req_ext;
   logic [ARB_OWNER_W:0]   sum;
   logic [ARB_OWNER_W-1:0] cand;

   assign req_ext = 4'(req);

   // Walk offsets from farthest to nearest so the nearest requester wins.
   always_comb begin
      valid = 1'b0;
      index = '0;
      sum   = '0;
      cand  = '0;
      for (int i = NREQ; i >= 1; i--) begin
         sum = {1'b0, last_owner} + (ARB_OWNER_W + 1)'(i);
         if (sum >= (ARB_OWNER_W + 1)'(NREQ)) begin
            sum = sum - (ARB_OWNER_W + 1)'(NREQ);
         end
         cand = sum[ARB_OWNER_W-1:0];
         if (req_ext[cand]) begin
            valid = 1'b1;
            index = cand;
         end
      end
   end

endmodule

// File: rtl/dma_bus_arbiter.sv
// 68000-style DMA bus arbiter: negotiates BR/BG/BGACK with the CPU wrapper and
// grants the bus round-robin to one of NREQ requesters, advancing on phi2 strobes.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | CPU owns the bus, no pending DMA request
// ST_REQ       | br_n asserted, waiting for bg_n
// ST_WAIT_IDLE | bus granted by CPU, waiting for as_n high (bus idle)
// ST_OWN       | one requester owns the bus, bgack_n asserted
// ST_REL       | one-strobe release back to the CPU
module dma_bus_arbiter
   import dma_bus_arbiter_pkg::*;
#(
   parameter int NREQ     = 3,
   parameter int HOLD_MAX = 64
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   phi2,
   input  logic [NREQ-1:0]        req,
   output logic [NREQ-1:0]        gnt,
   output logic [ARB_OWNER_W-1:0] owner,
   output logic                   busy,
   output logic                   preempt,
   output logic                   br_n,
   input  logic                   bg_n,
   output logic                   bgack_n,
   input  logic                   as_n
);

   localparam int HOLD_W = $clog2(HOLD_MAX + 1);

   arb_state_e             state_q, state_d;
   logic [ARB_OWNER_W-1:0] owner_q, owner_d;
   logic [ARB_OWNER_W-1:0] last_owner_q, last_owner_d;
   logic                   granted_q, granted_d;
   logic [HOLD_W-1:0]      hold_q, hold_d;
   logic [NREQ-1:0]        gnt_q, gnt_d;
   logic                   busy_q, busy_d;
   logic                   preempt_q, preempt_d;
   logic                   br_n_q, br_n_d;
   logic                   bgack_n_q, bgack_n_d;

   logic                   pick_valid;
   logic [ARB_OWNER_W-1:0] pick_idx;
   logic [3:0]             req_ext;

   assign req_ext = 4'(req);

   rr_pick #(.NREQ(NREQ)) u_rr_pick (
      .req        (req),
      .last_owner (last_owner_q),
      .valid      (pick_valid),
      .index      (pick_idx)
   );

   // Hold timer counts down from HOLD_MAX; terminal count (zero) means preempt.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      granted_d    = granted_q;
      hold_d       = hold_q;
      if (phi2) begin
         case (state_q)
            ST_IDLE: begin
               if (|req) state_d = ST_REQ;
            end
            ST_REQ: begin
               if (req == '0)  state_d = ST_IDLE;
               else if (!bg_n) state_d = ST_WAIT_IDLE;
            end
            ST_WAIT_IDLE: begin
               if (as_n) begin
                  if (pick_valid) begin
                     state_d   = ST_OWN;
                     owner_d   = pick_idx;
                     granted_d = 1'b1;
                     hold_d    = HOLD_W'(HOLD_MAX);
                  end else begin
                     state_d = ST_REL;
                  end
               end
            end
            ST_OWN: begin
               if (!req_ext[owner_q]) begin
                  state_d = ST_REL;
               end else if (hold_q != '0) begin
                  hold_d = hold_q - HOLD_W'(1);
               end
            end
            ST_REL: begin
               if (granted_q) last_owner_d = owner_q;
               granted_d = 1'b0;
               hold_d    = HOLD_W'(HOLD_MAX);
               state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Outputs are registered, decoded from the next state.
   always_comb begin
      br_n_d    = !((state_d == ST_REQ) || (state_d == ST_WAIT_IDLE));
      bgack_n_d = (state_d != ST_OWN);
      busy_d    = (state_d == ST_OWN);
      preempt_d = busy_d && (hold_d == '0);
      gnt_d     = '0;
      for (int i = 0; i < NREQ; i++) begin
         gnt_d[i] = busy_d && (owner_d == ARB_OWNER_W'(i));
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         owner_q      <= '0;
         last_owner_q <= ARB_OWNER_W'(NREQ - 1);
         granted_q    <= 1'b0;
         hold_q       <= HOLD_W'(HOLD_MAX);
         gnt_q        <= '0;
         busy_q       <= 1'b0;
         preempt_q    <= 1'b0;
         br_n_q       <= 1'b1;
         bgack_n_q    <= 1'b1;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         granted_q    <= granted_d;
         hold_q       <= hold_d;
         gnt_q        <= gnt_d;
         busy_q       <= busy_d;
         preempt_q    <= preempt_d;
         br_n_q       <= br_n_d;
         bgack_n_q    <= bgack_n_d;
      end
   end

   assign gnt     = gnt_q;
   assign owner   = owner_q;
   assign busy    = busy_q;
   assign preempt = preempt_q;
   assign br_n    = br_n_q;
   assign bgack_n = bgack_n_q;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Directed bench for dma_bus_arbiter (NREQ=3, HOLD_MAX=4); phi2 strobes every other clk.
module tb_dma_bus_arbiter;

   localparam int NREQ     = 3;
   localparam int HOLD_MAX = 4;

   logic            clk;
   logic            reset_n;
   logic            phi2;
   logic [NREQ-1:0] req;
   logic [NREQ-1:0] gnt;
   logic [1:0]      owner;
   logic            busy;
   logic            preempt;
   logic            br_n;
   logic            bg_n;
   logic            bgack_n;
   logic            as_n;

   int n_cmp;
   int n_bad;

   dma_bus_arbiter #(.NREQ(NREQ), .HOLD_MAX(HOLD_MAX)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .phi2    (phi2),
      .req     (req),
      .gnt     (gnt),
      .owner   (owner),
      .busy    (busy),
      .preempt (preempt),
      .br_n    (br_n),
      .bg_n    (bg_n),
      .bgack_n (bgack_n),
      .as_n    (as_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_bus(input string tag, input logic [NREQ-1:0] exp_gnt,
                          input logic exp_br_n, input logic exp_bgack_n);
      chk({tag, ".gnt"},     32'(gnt),     32'(exp_gnt));
      chk({tag, ".busy"},    32'(busy),    32'(|exp_gnt));
      chk({tag, ".br_n"},    32'(br_n),    32'(exp_br_n));
      chk({tag, ".bgack_n"}, 32'(bgack_n), 32'(exp_bgack_n));
   endtask

   // One phi2 strobe edge followed by one idle (phi2=0) edge.
   task automatic strobe();
      phi2 = 1'b1;
      @(posedge clk); #1;
      phi2 = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      n_cmp   = 0;
      n_bad   = 0;
      reset_n = 1'b0;
      phi2    = 1'b0;
      req     = '0;
      bg_n    = 1'b1;
      as_n    = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk_bus("reset", 3'b000, 1'b1, 1'b1);
      chk("reset.preempt", 32'(preempt), 32'd0);
      chk("reset.owner",   32'(owner),   32'd0);
      reset_n = 1'b1;
      @(posedge clk); #1;

      // No activity on edges without phi2
      req = 3'b001;
      repeat (3) begin @(posedge clk); #1; end
      chk_bus("nophi2", 3'b000, 1'b1, 1'b1);

      // Single tenure: bg_n falls two strobes after br_n
      strobe();
      chk_bus("t1.req", 3'b000, 1'b0, 1'b1);
      strobe();
      chk_bus("t1.req2", 3'b000, 1'b0, 1'b1);
      bg_n = 1'b0;
      strobe();
      chk_bus("t1.wait", 3'b000, 1'b0, 1'b1);
      strobe();
      chk_bus("t1.own", 3'b001, 1'b1, 1'b0);
      chk("t1.owner", 32'(owner), 32'd0);
      req  = 3'b000;
      bg_n = 1'b1;
      strobe();
      chk_bus("t1.rel", 3'b000, 1'b1, 1'b1);
      strobe();
      chk_bus("t1.idle", 3'b000, 1'b1, 1'b1);

      // Round robin from reset with all three requesting
      do_reset();
      req  = 3'b111;
      bg_n = 1'b0;
      as_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         logic [NREQ-1:0] exp_g;
         exp_g = NREQ'(1 << (k % NREQ));
         strobe();
         chk_bus("rr.req", 3'b000, 1'b0, 1'b1);
         strobe();
         strobe();
         chk_bus("rr.own", exp_g, 1'b1, 1'b0);
         chk("rr.owner", 32'(owner), 32'(k % NREQ));
         req = 3'b111 & ~exp_g;
         strobe();
         chk_bus("rr.rel", 3'b000, 1'b1, 1'b1);
         req = 3'b111;
         strobe();
         chk_bus("rr.idle", 3'b000, 1'b1, 1'b1);
      end
      // last owner is now 0

      // Bus held busy by the CPU: stay in WAIT_IDLE until as_n rises
      req  = 3'b010;
      bg_n = 1'b0;
      as_n = 1'b0;
      strobe();
      strobe();
      for (int k = 0; k < 5; k++) begin
         strobe();
         chk_bus("wait.as", 3'b000, 1'b0, 1'b1);
      end
      as_n = 1'b1;
      strobe();
      chk_bus("wait.own", 3'b010, 1'b1, 1'b0);
      chk("wait.owner", 32'(owner), 32'd1);
      req = 3'b000;
      strobe();
      strobe();

      // Request withdrawn before bg_n
      bg_n = 1'b1;
      req  = 3'b100;
      strobe();
      chk_bus("drop.req", 3'b000, 1'b0, 1'b1);
      req = 3'b000;
      strobe();
      chk_bus("drop.idle", 3'b000, 1'b1, 1'b1);
      strobe();
      chk_bus("drop.idle2", 3'b000, 1'b1, 1'b1);

      // Preempt after HOLD_MAX strobes, grant kept
      req  = 3'b100;
      bg_n = 1'b0;
      strobe();
      strobe();
      strobe();
      chk_bus("hold.own", 3'b100, 1'b1, 1'b0);
      chk("hold.pre0", 32'(preempt), 32'd0);
      for (int k = 1; k <= 10; k++) begin
         strobe();
         chk("hold.preempt", 32'(preempt), 32'(k >= HOLD_MAX));
         chk("hold.gnt", 32'(gnt), 32'b100);
      end
      req = 3'b000;
      strobe();
      chk_bus("hold.rel", 3'b000, 1'b1, 1'b1);
      chk("hold.pre_rel", 32'(preempt), 32'd0);
      strobe();

      // Req vanishes in WAIT_IDLE: release without a grant, last owner untouched
      req  = 3'b010;
      as_n = 1'b0;
      strobe();
      strobe();
      req  = 3'b000;
      as_n = 1'b1;
      strobe();
      chk_bus("nogrant.rel", 3'b000, 1'b1, 1'b1);
      strobe();
      req = 3'b011;
      strobe();
      strobe();
      strobe();
      chk_bus("nogrant.next", 3'b001, 1'b1, 1'b0);

      // Asynchronous reset mid-tenure
      #3;
      reset_n = 1'b0;
      #1;
      chk_bus("async", 3'b000, 1'b1, 1'b1);
      chk("async.preempt", 32'(preempt), 32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      req     = 3'b000;
      @(posedge clk); #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
